rom_loader: RTL
===============

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter NCH, default 2, number of SDRAM write channels (1..4).
REQ-002 SHALL have parameter REGION_BASE, default {25'h0E000, 25'h00000} (index 1, index 0), packed NCH x 25-bit byte base per channel.
REQ-003 SHALL have parameter REGION_SIZE, default {25'h08000, 25'h0E000}, packed NCH x 25-bit byte length per channel.
REQ-004 SHALL have parameter RESET_HOLD, default 16, cycles core_reset stays high after load completes.
REQ-005 SHALL have ports:
 clk_sys in 1: single clock
 RESETn in 1: synchronous, active-low reset
 ioctl_download in 1: download window active
 ioctl_wr in 1: byte strobe level
 ioctl_addr in 25: byte address
 ioctl_dout in 8: byte data
 ext_reset in 1: menu/button reset request
 port_req out NCH: per-channel toggle request
 port_ack in NCH: per-channel toggle acknowledge
 port_a out NCH*23: word address
 port_ds out NCH*2: byte selects {hi,lo}
 port_d out NCH*16: data, byte duplicated
 port_we out NCH: write enable
 rom_loaded out 1: at least one complete download seen
 core_reset out 1: active-high reset to the game core
 overrun out 1: sticky, byte dropped because channel busy
 busy out 1: FSM not in IDLE/DONE

Function
REQ-006 SHALL detect a write as ioctl_wr high with its registered previous value low, only while ioctl_download=1.
REQ-007 SHALL map a detected byte to the lowest-index channel c where REGION_BASE[c] <= ioctl_addr < REGION_BASE[c]+REGION_SIZE; unmatched bytes SHALL be dropped silently.
REQ-008 SHALL, one cycle after detection, present local=ioctl_addr-REGION_BASE[c], port_a[c]=local[23:1], port_ds[c]={local[0],~local[0]}, port_d[c]={dout,dout}, and toggle port_req[c].
REQ-009 SHALL treat channel c as pending while port_req[c]!=port_ack[c]; outputs of a pending channel SHALL stay stable.
REQ-010 SHALL drop a byte targeting a pending channel and set overrun; other channels are unaffected.
REQ-011 SHALL hold port_we[c]=1 whenever state is LOAD or DRAIN, else 0.
REQ-012 SHALL implement FSM IDLE -> LOAD (ioctl_download rises) -> DRAIN (ioctl_download falls) -> DONE (no channel pending) -> LOAD (ioctl_download rises again).
REQ-013 SHALL clear overrun on every IDLE/DONE -> LOAD transition.
REQ-014 SHALL set rom_loaded on entry to DONE; it SHALL remain set until RESETn.
REQ-015 SHALL drive core_reset = ext_reset OR state!=DONE OR hold counter nonzero; counter loads RESET_HOLD on DONE entry and decrements to 0.
REQ-016 SHALL keep core_reset high through any new download (LOAD/DRAIN) after rom_loaded.
REQ-017 SHALL use 25-bit subtraction for local address; bits above 23 ignored.

Reset
REQ-018 RESETn low at a clock edge SHALL force state IDLE, port_req=0, port_a/ds/d=0, port_we=0, overrun=0, rom_loaded=0, core_reset=1, hold counter=0, busy=0, checksum=0.
REQ-019 Reset mid-download SHALL abandon pending requests; bytes arriving while RESETn=0 SHALL be ignored; a download already in progress when RESETn rises SHALL be entered as LOAD on the next ioctl_download rising edge only.

Configuration
REQ-020 With LOADER_CHECKSUM_EN defined, SHALL add output checksum[7:0]: mod-256 sum of all accepted (routed, not dropped) bytes, cleared on entry to LOAD, frozen in DONE.
REQ-021 Without LOADER_CHECKSUM_EN, port checksum and its adder SHALL not exist.

Structure
REQ-022 FSM state enum, MAX_NCH=4 and address width constant (25) SHALL live in shared package loader_pkg.
REQ-023 Per-channel request/ack register set SHALL be sub-module loader_chan, instantiated NCH times via generate.

Verification
REQ-024 Byte 8'hA5 at 25'h00003, channel 0 idle -> next cycle port_a[0]=23'h000001, port_ds[0]=2'b10, port_d[0]=16'hA5A5, port_req[0] toggles.
REQ-025 Byte at 25'h0E001 -> channel 1 with port_a=0, port_ds=2'b10; byte at 25'h16000 -> no toggle on any channel.
REQ-026 Second byte to channel 0 before port_ack[0] toggles -> dropped, overrun=1; next download start -> overrun=0.
REQ-027 ioctl_download falls with channel 1 pending; ack after 5 cycles -> DONE entered the cycle after ack, rom_loaded=1, core_reset falls exactly RESET_HOLD cycles later.
REQ-028 RESETn low for 1 cycle during LOAD -> all outputs at REQ-018 values, rom_loaded=0, core_reset=1.
REQ-029 With LOADER_CHECKSUM_EN, bytes 8'hFF,8'h02,8'h10 accepted -> checksum=8'h11.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the ROM loader.
package loader_pkg;

    localparam int MAX_NCH = 4;
    localparam int ADDR_W  = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loaderState_e;

endpackage

// File: rtl/loader_chan.sv
// One SDRAM write channel: holds a word request and toggles req to hand it off.
module loader_chan (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        load_i,
    input  logic [22:0] addr_i,
    input  logic [1:0]  ds_i,
    input  logic [7:0]  data_i,
    input  logic        ack_i,
    output logic        req_o,
    output logic [22:0] addr_o,
    output logic [1:0]  ds_o,
    output logic [15:0] data_o,
    output logic        pending_o
);

    logic        req_q, req_d;
    logic [22:0] addr_q, addr_d;
    logic [1:0]  ds_q, ds_d;
    logic [15:0] data_q, data_d;

    // Outputs only move on a fresh load, so they stay stable while pending.
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        ds_d   = ds_q;
        data_d = data_q;
        if (load_i) begin
            req_d  = ~req_q;
            addr_d = addr_i;
            ds_d   = ds_i;
            data_d = {data_i, data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            ds_q   <= '0;
            data_q <= '0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            ds_q   <= ds_d;
            data_q <= data_d;
        end
    end

    assign req_o     = req_q;
    assign addr_o    = addr_q;
    assign ds_o      = ds_q;
    assign data_o    = data_q;
    assign pending_o = req_q ^ ack_i;

endmodule

// File: rtl/rom_loader.sv
// Routes ioctl download bytes into per-region SDRAM channels and sequences core reset.
// Optional LOADER_CHECKSUM_EN adds a mod-256 checksum output of accepted bytes.
module rom_loader
    import loader_pkg::*;
#(
    parameter int                      NCH         = 2,
    parameter logic [NCH*ADDR_W-1:0]   REGION_BASE = {25'h0E000, 25'h00000},
    parameter logic [NCH*ADDR_W-1:0]   REGION_SIZE = {25'h08000, 25'h0E000},
    parameter int                      RESET_HOLD  = 16
) (
    input  logic                 clk_sys,
    input  logic                 RESETn,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 ext_reset,
    output logic [NCH-1:0]       port_req,
    input  logic [NCH-1:0]       port_ack,
    output logic [NCH*23-1:0]    port_a,
    output logic [NCH*2-1:0]     port_ds,
    output logic [NCH*16-1:0]    port_d,
    output logic [NCH-1:0]       port_we,
    output logic                 rom_loaded,
    output logic                 core_reset,
    output logic                 overrun,
    output logic                 busy
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]           checksum
`endif
);

    localparam int HOLD_W  = $clog2(RESET_HOLD + 2);
    localparam int CHSEL_W = $clog2(MAX_NCH);

    loaderState_e        state_q, state_d;
    logic                wrPrev_q, dlPrev_q;
    logic                overrun_q, overrun_d;
    logic                loaded_q, loaded_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                byteStrobe, dlRise, stLoad, startLoad;
    logic                hit, collide, loadAny;
    logic [CHSEL_W-1:0]  chanSel;
    logic [23:0]         localAddr;
    logic [ADDR_W-1:0]   base, size;
    logic [NCH-1:0]      selOneHot, chanLoad, pending;

    assign byteStrobe = ioctl_download & ioctl_wr & ~wrPrev_q;
    assign dlRise     = ioctl_download & ~dlPrev_q;
    assign stLoad     = (state_q == ST_LOAD);
    assign startLoad  = dlRise & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // Walk channels from highest to lowest so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        chanSel   = '0;
        localAddr = '0;
        base      = '0;
        size      = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            base = REGION_BASE[c*ADDR_W +: ADDR_W];
            size = REGION_SIZE[c*ADDR_W +: ADDR_W];
            if (({1'b0, ioctl_addr} >= {1'b0, base}) &&
                ({1'b0, ioctl_addr} <  ({1'b0, base} + {1'b0, size}))) begin
                hit       = 1'b1;
                chanSel   = CHSEL_W'(c);
                localAddr = 24'(ioctl_addr - base);
            end
        end
    end

    always_comb begin
        selOneHot = '0;
        chanLoad  = '0;
        for (int c = 0; c < NCH; c++) begin
            selOneHot[c] = stLoad & byteStrobe & hit & (chanSel == CHSEL_W'(c));
            chanLoad[c]  = selOneHot[c] & ~pending[c];
        end
    end

    assign collide = |(selOneHot & pending);
    assign loadAny = |chanLoad;

    for (genvar g = 0; g < NCH; g++) begin : gChan
        loader_chan u_chan (
            .clk_i     (clk_sys),
            .rstn_i    (RESETn),
            .load_i    (chanLoad[g]),
            .addr_i    (localAddr[23:1]),
            .ds_i      ({localAddr[0], ~localAddr[0]}),
            .data_i    (ioctl_dout),
            .ack_i     (port_ack[g]),
            .req_o     (port_req[g]),
            .addr_o    (port_a[g*23 +: 23]),
            .ds_o      (port_ds[g*2 +: 2]),
            .data_o    (port_d[g*16 +: 16]),
            .pending_o (pending[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        loaded_d  = loaded_q;
        hold_d    = hold_q;
        if ((state_q == ST_DONE) && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (dlRise) begin
                    state_d   = ST_LOAD;
                    overrun_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (collide) begin
                    overrun_d = 1'b1;
                end
                if (!ioctl_download) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pending == '0) begin
                    state_d  = ST_DONE;
                    loaded_d = 1'b1;
                    hold_d   = HOLD_W'(RESET_HOLD);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // dlPrev_q resets high so a download already underway at reset release is not taken as a start.
    always_ff @(posedge clk_sys) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            wrPrev_q  <= 1'b0;
            dlPrev_q  <= 1'b1;
            overrun_q <= 1'b0;
            loaded_q  <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            wrPrev_q  <= ioctl_wr;
            dlPrev_q  <= ioctl_download;
            overrun_q <= overrun_d;
            loaded_q  <= loaded_d;
            hold_q    <= hold_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (startLoad) begin
            sum_d = 8'h00;
        end else if (loadAny) begin
            sum_d = sum_q + ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!RESETn) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unusedStart;
    assign unusedStart = startLoad | loadAny;
`endif

    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign port_we    = {NCH{busy}};
    assign rom_loaded = loaded_q;
    assign overrun    = overrun_q;
    assign core_reset = ext_reset | (state_q != ST_DONE) | (hold_q != '0);

endmodule
